// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with conditional execution, NZCV flag register and annul counter.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] ALUresult_i,
  input  logic [3:0]        NZCV_i,
  input  logic              setflags_i,
  input  logic [3:0]        cond_i,
  input  logic              branch_i,
  input  logic [DATA_W-1:0] branch_target_i,
  input  logic [RA_W-1:0]   rd_addr_i,
  input  logic              regwrite_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] ALUresult_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [DATA_W-1:0] branch_target_o,
  output logic [RA_W-1:0]   rd_addr_o,
  output logic              regwrite_o,
  output logic              memread_o,
  output logic              memwrite_o,
  output logic              branch_taken_o,
  output logic [3:0]        flags_o,
  output logic [15:0]       annul_cnt_o
);
  logic n, z, c, v, cond_pass, exec;
  logic [15:0] pass_tbl;
  // Conditions are judged on the committed flags, so a flag-setting op never sees its own result.
  always_comb begin
    {n, z, c, v} = flags_o;
    pass_tbl = {1'b0, 1'b1, z | (n != v), !z & (n == v), n != v, n == v, !c | z, c & !z,
                !v, v, !n, n, !c, c, !z, z};
    cond_pass = pass_tbl[cond_i];
    exec = valid_i & cond_pass;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o         <= 1'b0;
      ALUresult_o     <= '0;
      store_data_o    <= '0;
      branch_target_o <= '0;
      rd_addr_o       <= '0;
      regwrite_o      <= 1'b0;
      memread_o       <= 1'b0;
      memwrite_o      <= 1'b0;
      branch_taken_o  <= 1'b0;
      flags_o         <= 4'b0000;
      annul_cnt_o     <= 16'd0;
    end else if (flush_i) begin
      valid_o        <= 1'b0;
      regwrite_o     <= 1'b0;
      memread_o      <= 1'b0;
      memwrite_o     <= 1'b0;
      branch_taken_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o         <= valid_i;
      ALUresult_o     <= ALUresult_i;
      store_data_o    <= store_data_i;
      branch_target_o <= branch_target_i;
      rd_addr_o       <= rd_addr_i;
      regwrite_o      <= exec & regwrite_i;
      memread_o       <= exec & memread_i;
      memwrite_o      <= exec & memwrite_i;
      branch_taken_o  <= exec & branch_i;
      if (exec && setflags_i) flags_o <= NZCV_i;
      if (valid_i && !cond_pass && annul_cnt_o != 16'hFFFF) annul_cnt_o <= annul_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: randomized and directed checks of ex_mem_reg against a behavioural pipeline model.
module tb_ex_mem_reg;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        stall_i, flush_i, valid_i, setflags_i, branch_i, regwrite_i, memread_i, memwrite_i;
  logic [31:0] ALUresult_i, branch_target_i, store_data_i;
  logic [3:0]  NZCV_i, cond_i;
  logic [4:0]  rd_addr_i;
  logic        valid_o, regwrite_o, memread_o, memwrite_o, branch_taken_o;
  logic [31:0] ALUresult_o, store_data_o, branch_target_o;
  logic [4:0]  rd_addr_o;
  logic [3:0]  flags_o;
  logic [15:0] annul_cnt_o;
  int n_pass = 0, n_checks = 0;
  logic        e_valid, e_rw, e_mr, e_mw, e_bt;
  logic [31:0] e_alu, e_sd, e_tgt;
  logic [4:0]  e_rd;
  logic [3:0]  e_flags;
  logic [15:0] e_cnt;

  ex_mem_reg dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ALUresult_i(ALUresult_i), .NZCV_i(NZCV_i), .setflags_i(setflags_i), .cond_i(cond_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i), .rd_addr_i(rd_addr_i),
    .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .store_data_i(store_data_i), .valid_o(valid_o), .ALUresult_o(ALUresult_o),
    .store_data_o(store_data_o), .branch_target_o(branch_target_o), .rd_addr_o(rd_addr_o),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .branch_taken_o(branch_taken_o), .flags_o(flags_o), .annul_cnt_o(annul_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit arm_pass(input logic [3:0] cc, input logic [3:0] f);
    bit fn = f[3], fz = f[2], fc = f[1], fv = f[0];
    case (cc)
      4'h0: return fz;          4'h1: return !fz;
      4'h2: return fc;          4'h3: return !fc;
      4'h4: return fn;          4'h5: return !fn;
      4'h6: return fv;          4'h7: return !fv;
      4'h8: return fc && !fz;   4'h9: return !fc || fz;
      4'hA: return fn == fv;    4'hB: return fn != fv;
      4'hC: return !fz && fn == fv;
      4'hD: return fz || fn != fv;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    {e_valid, e_rw, e_mr, e_mw, e_bt} = '0;
    e_alu = 0; e_sd = 0; e_tgt = 0; e_rd = 0; e_flags = 0; e_cnt = 0;
  endtask

  task automatic model_edge();
    bit ex;
    if (flush_i) {e_valid, e_rw, e_mr, e_mw, e_bt} = '0;
    else if (!stall_i) begin
      ex = valid_i && arm_pass(cond_i, e_flags);
      e_valid = valid_i; e_alu = ALUresult_i; e_sd = store_data_i; e_tgt = branch_target_i;
      e_rd = rd_addr_i; e_rw = ex && regwrite_i; e_mr = ex && memread_i;
      e_mw = ex && memwrite_i; e_bt = ex && branch_i;
      if (ex && setflags_i) e_flags = NZCV_i;
      if (valid_i && !ex && e_cnt < 16'hFFFF) e_cnt = e_cnt + 1;
    end
  endtask

  task automatic check_all();
    check("valid", valid_o, e_valid);
    check("alu", ALUresult_o, e_alu);
    check("store", store_data_o, e_sd);
    check("target", branch_target_o, e_tgt);
    check("rd", rd_addr_o, e_rd);
    check("regwrite", regwrite_o, e_rw);
    check("memread", memread_o, e_mr);
    check("memwrite", memwrite_o, e_mw);
    check("taken", branch_taken_o, e_bt);
    check("flags", flags_o, e_flags);
    check("annul_cnt", annul_cnt_o, e_cnt);
  endtask

  task automatic clear_inputs();
    {stall_i, flush_i, valid_i, setflags_i, branch_i, regwrite_i, memread_i, memwrite_i} = '0;
    ALUresult_i = 0; branch_target_i = 0; store_data_i = 0; NZCV_i = 0; cond_i = 0; rd_addr_i = 0;
  endtask

  task automatic rand_inputs();
    stall_i = ($urandom_range(7) == 0); flush_i = ($urandom_range(7) == 0);
    valid_i = ($urandom_range(3) != 0); setflags_i = $urandom; branch_i = $urandom;
    regwrite_i = $urandom; memread_i = $urandom; memwrite_i = $urandom;
    ALUresult_i = $urandom; branch_target_i = $urandom; store_data_i = $urandom;
    NZCV_i = $urandom; cond_i = $urandom; rd_addr_i = $urandom;
  endtask

  task automatic apply(input bit do_check);
    @(posedge clk_i);
    model_edge();
    #1;
    if (do_check) check_all();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 check_all();
    @(negedge clk_i) rst_n_i = 1'b1;
    #4;
    // flag update then EQ sees the new Z
    valid_i = 1; setflags_i = 1; cond_i = 4'hE; NZCV_i = 4'b0100;
    apply(1);
    check("req18_flags", flags_o, 4'b0100);
    check("req18_valid", valid_o, 1);
    setflags_i = 0; cond_i = 4'h0; regwrite_i = 1;
    apply(1);
    check("req18_rw", regwrite_o, 1);
    // annulled EQ on clear flags
    clear_inputs(); valid_i = 1; setflags_i = 1; cond_i = 4'hE; NZCV_i = 4'b0000;
    apply(1);
    clear_inputs(); valid_i = 1; cond_i = 4'h0; regwrite_i = 1; memwrite_i = 1;
    apply(1);
    check("req19_rw", regwrite_o, 0);
    check("req19_mw", memwrite_o, 0);
    check("req19_valid", valid_o, 1);
    check("req19_cnt", annul_cnt_o, 1);
    // branch LT / GE with N=1, V=0
    clear_inputs(); valid_i = 1; setflags_i = 1; cond_i = 4'hE; NZCV_i = 4'b1000;
    apply(1);
    clear_inputs(); valid_i = 1; cond_i = 4'hB; branch_i = 1; branch_target_i = 32'h40;
    apply(1);
    check("req20_lt", branch_taken_o, 1);
    check("req20_tgt", branch_target_o, 32'h40);
    cond_i = 4'hA;
    apply(1);
    check("req20_ge", branch_taken_o, 0);
    // stall with changing inputs, then stall+flush
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); stall_i = 1; flush_i = 0;
      apply(1);
    end
    rand_inputs(); stall_i = 1; flush_i = 1; valid_i = 1; setflags_i = 1; cond_i = 4'hE;
    apply(1);
    check("req21_valid", valid_o, 0);
    check("req21_rw", regwrite_o, 0);
    check("req21_flags", flags_o, 4'b1000);
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      apply(1);
    end
    // async reset between edges
    #3 rst_n_i = 1'b0;
    model_reset();
    #1 check_all();
    check("async_valid", valid_o, 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    #4;
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      apply(1);
    end
    // drive the annul counter into saturation with NV instructions
    clear_inputs(); valid_i = 1; cond_i = 4'hF;
    for (int i = 0; i < 65536; i++) apply(0);
    check_all();
    check("sat_cnt", annul_cnt_o, 16'hFFFF);
    apply(1);
    apply(1);
    check("sat_hold", annul_cnt_o, 16'hFFFF);
    #3 rst_n_i = 1'b0;
    model_reset();
    #1 check_all();
    check("reset_cnt", annul_cnt_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameters, one per line as name, default, meaning:
- DATA_W, 32, datapath width.
- RA_W, 5, register address width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk_i  in  1  the single clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- stall_i  in  1  hold all registered state.
- flush_i  in  1  insert bubble.
- valid_i  in  1  EX holds a real instruction.
- ALUresult_i  in  DATA_W  ALU result.
- NZCV_i  in  4  ALU flags {N,Z,C,V}.
- setflags_i  in  1  instruction updates the flag register.
- cond_i  in  4  condition code.
- branch_i  in  1  conditional branch.
- branch_target_i  in  DATA_W  branch target.
- rd_addr_i  in  RA_W  destination register.
- regwrite_i, memread_i, memwrite_i  in  1 each  control bits.
- store_data_i  in  DATA_W  store data.
- valid_o  out  1  MEM holds a real instruction.
- ALUresult_o, store_data_o, branch_target_o  out  DATA_W  registered copies.
- rd_addr_o  out  RA_W  registered destination register.
- regwrite_o, memread_o, memwrite_o  out  1 each  registered, qualified control bits.
- branch_taken_o  out  1  registered branch resolution.
- flags_o  out  4  committed NZCV register.
- annul_cnt_o  out  16  count of condition-failed instructions.

Function
REQ-003 cond_pass SHALL be combinational, evaluated on flags_o (N,Z,C,V):
- 0 EQ: Z.
- 1 NE: !Z.
- 2 CS: C.
- 3 CC: !C.
- 4 MI: N.
- 5 PL: !N.
- 6 VS: V.
- 7 VC: !V.
- 8 HI: C&!Z.
- 9 LS: !C|Z.
- A GE: N==V.
- B LT: N!=V.
- C GT: !Z&(N==V).
- D LE: Z|(N!=V).
- E AL: 1.
- F NV: 0.
REQ-004 "Advance" SHALL be: stall_i=0 and flush_i=0.
REQ-005 On advance, every output register SHALL capture its input at the rising clock edge; latency 1 cycle.
REQ-006 Captured control bits SHALL be qualified:
- regwrite_o = valid_i & cond_pass & regwrite_i; memread_o and memwrite_o likewise.
- branch_taken_o = valid_i & cond_pass & branch_i.
REQ-007 valid_o SHALL capture valid_i, so an annulled instruction still advances as a valid no-op.
REQ-008 On advance with valid_i=1, setflags_i=1 and cond_pass=1, flags_o SHALL load NZCV_i; otherwise flags_o SHALL hold.
REQ-009 On advance with valid_i=1 and cond_pass=0, annul_cnt_o SHALL increment by 1; it SHALL saturate at 16'hFFFF with no wrap.
REQ-010 With stall_i=1 and flush_i=0, all registers SHALL hold, including flags_o and annul_cnt_o.
REQ-011 flush_i=1 SHALL take priority over stall_i. At the next edge:
- valid_o, regwrite_o, memread_o, memwrite_o and branch_taken_o go to 0.
- Data outputs hold.
- flags_o and annul_cnt_o are not updated.
REQ-012 Within one cycle, cond_pass SHALL use flags_o as they were before the edge, so a flag-setting instruction never affects its own condition. The next instruction sees the new flags with no hazard.
REQ-013 Back-to-back advances SHALL sustain one instruction per cycle.
REQ-014 No output SHALL depend combinationally on any input.

Reset
REQ-015 While rst_n_i=0, every output SHALL be 0 asynchronously, including flags_o=4'b0000 and annul_cnt_o=0.
REQ-016 After rst_n_i rises, the first capture SHALL occur at the first rising edge that meets the advance condition.
REQ-017 Reset asserted mid-stall or mid-flush SHALL override both.

Verification
REQ-018 Flag update: valid_i=1, setflags_i=1, cond_i=E, NZCV_i=0100, ALUresult_i=0 -> next edge flags_o=0100, valid_o=1. Next instruction with cond_i=0 (EQ) and regwrite_i=1 -> regwrite_o=1.
REQ-019 Annul: flags_o=0000, cond_i=0 (EQ), regwrite_i=1, memwrite_i=1 -> regwrite_o=0, memwrite_o=0, valid_o=1, annul_cnt_o=1.
REQ-020 Branch: flags_o=1000 (N=1, V=0), cond_i=B (LT), branch_i=1, branch_target_i=32'h0000_0040 -> branch_taken_o=1, branch_target_o=32'h40. Same with cond_i=A (GE) -> branch_taken_o=0.
REQ-021 Stall/flush:
- stall_i=1 for 3 cycles with changing inputs -> all outputs constant.
- stall_i=1 and flush_i=1 together -> valid_o=0, regwrite_o=0, flags_o unchanged.
REQ-022 Saturation and reset: force 65536 annulled instructions -> annul_cnt_o=16'hFFFF and stays there. Assert rst_n_i between clock edges -> all outputs 0 immediately.
